// File: rtl/random_engine_pkg.sv
// Shared definitions for the random sample reader: FSM encodings and default sizing.
package random_engine_pkg;

    localparam int DEF_NBITS = 8;
    localparam int DEF_DEPTH = 4;
    localparam int STATE_W   = 2;
    localparam int COUNT_W   = 8;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/register.sv
// Generic enable-gated register cell with synchronous active-high reset.
module register #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sample_fifo.sv
// Sample buffer: NBITS x DEPTH circular FIFO, simultaneous push/pop keeps occupancy.
module sample_fifo #(
    parameter int NBITS = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [NBITS-1:0] wdata,
    output logic [NBITS-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             almost_full
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [NBITS-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_push     = push && !full;
    assign do_pop      = pop && !empty;
    assign full        = (count == CNT_W'(DEPTH));
    assign almost_full = (count == CNT_W'(DEPTH - 1));
    assign empty       = (count == '0);
    assign rdata       = mem[rd_ptr];

    // Storage carries no reset; only the pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/random_sample_reader.sv
// Burst reader: starts/stops a random engine, buffers its samples and streams them out.
module random_sample_reader import random_engine_pkg::*; #(
    parameter int NBITS = DEF_NBITS,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_val,
    output logic               req_rdy,
    input  logic [COUNT_W-1:0] req_count,
    output logic               eng_start,
    output logic               eng_stop,
    input  logic               eng_active,
    input  logic [NBITS-1:0]   eng_data,
    output logic               resp_val,
    input  logic               resp_rdy,
    output logic [NBITS-1:0]   resp_data,
    output logic               busy,
    output logic               done,
    output logic [STATE_W-1:0] dbg_state
);

    state_t             state;
    state_t             state_nxt;
    logic [STATE_W-1:0] state_q;
    logic [COUNT_W-1:0] remaining;
    logic [COUNT_W-1:0] remaining_nxt;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_almost_full;

    register #(.WIDTH(STATE_W), .RESET_VALUE(STATE_W'(IDLE))) u_state_reg (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (state_nxt),
        .q   (state_q)
    );

    register #(.WIDTH(COUNT_W), .RESET_VALUE('0)) u_remaining_reg (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (remaining_nxt),
        .q   (remaining)
    );

    sample_fifo #(.NBITS(NBITS), .DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .pop         (pop),
        .wdata       (eng_data),
        .rdata       (resp_data),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .almost_full (fifo_almost_full)
    );

    assign state     = state_t'(state_q);
    assign dbg_state = state_q;
    assign busy      = (state != IDLE);
    assign resp_val  = !fifo_empty;
    assign pop       = resp_val && resp_rdy;

    // Handshakes: a request moves on req_val && req_rdy, a sample leaves on
    // resp_val && resp_rdy; the engine delivers one sample per eng_active cycle.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        req_rdy       = 1'b0;
        eng_start     = 1'b0;
        eng_stop      = 1'b0;
        push          = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: begin
                req_rdy = 1'b1;
                if (req_val) begin
                    if (req_count != '0) begin
                        remaining_nxt = req_count;
                        state_nxt     = START;
                    end else begin
                        state_nxt = DRAIN;
                    end
                end
            end
            START: begin
                if (!fifo_full) begin
                    eng_start = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (eng_active && !fifo_full) begin
                    push = 1'b1;
                    if (remaining != '0) begin
                        remaining_nxt = remaining - COUNT_W'(1);
                    end
                    if (remaining <= COUNT_W'(1)) begin
                        eng_stop  = 1'b1;
                        state_nxt = DRAIN;
                    end else if (fifo_almost_full && !pop) begin
                        // This capture takes the last free slot: pause the engine.
                        eng_stop  = 1'b1;
                        state_nxt = START;
                    end
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_random_sample_reader.sv
// Bench for random_sample_reader: LFSR engine model, sample scoreboard, directed and random bursts.
module tb_random_sample_reader;

    localparam int NBITS = 8;
    localparam int DEPTH = 4;
    localparam logic [NBITS-1:0] SEED = 8'h5A;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_val = 1'b0;
    logic             req_rdy;
    logic [7:0]       req_count = 8'd0;
    logic             eng_start;
    logic             eng_stop;
    logic             eng_active = 1'b0;
    logic [NBITS-1:0] eng_data = SEED;
    logic             resp_val;
    logic             resp_rdy = 1'b1;
    logic [NBITS-1:0] resp_data;
    logic             busy;
    logic             done;
    logic [1:0]       dbg_state;

    random_sample_reader #(.NBITS(NBITS), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_val    (req_val),
        .req_rdy    (req_rdy),
        .req_count  (req_count),
        .eng_start  (eng_start),
        .eng_stop   (eng_stop),
        .eng_active (eng_active),
        .eng_data   (eng_data),
        .resp_val   (resp_val),
        .resp_rdy   (resp_rdy),
        .resp_data  (resp_data),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial forever #5 clk = ~clk;

    // ---------------- bench state ----------------
    int total = 0;
    int bad   = 0;

    logic [NBITS-1:0] exp_q[$];
    logic [NBITS-1:0] model_lfsr = SEED;
    logic [NBITS-1:0] eng_lfsr   = SEED;
    logic             nxt_active = 1'b0;
    int               rdy_mode   = 0;
    int cyc = 0, occ = 0;
    int caps = 0, stops = 0, last_stop_caps = 0, pops = 0, dones = 0, starts = 0, accepts = 0;
    int last_pop_cyc = 0, done_cyc = 0, accept_cyc = 0, last_cap_cyc = 0;

    typedef struct {
        int count;
        int mode;
        int exp_pops;
        int exp_no_start;
    } vec_t;
    vec_t vecs[8];

    function automatic logic [NBITS-1:0] lfsr_step(input logic [NBITS-1:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    // Engine model, scoreboard and protocol monitor, sampled mid-cycle.
    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                occ = 0;
                if (eng_active) eng_lfsr = lfsr_step(eng_lfsr);
                nxt_active = 1'b0;
                model_lfsr = eng_lfsr;
            end else begin
                check("start_stop_exclusive", int'(eng_start && eng_stop), 0);
                check("req_rdy_vs_busy", int'(req_rdy), int'(!busy));
                check("resp_val_vs_occupancy", int'(resp_val), int'(occ != 0));
                if (req_val && req_rdy) begin
                    accepts++;
                    accept_cyc = cyc;
                    for (int i = 0; i < int'(req_count); i++) begin
                        exp_q.push_back(model_lfsr);
                        model_lfsr = lfsr_step(model_lfsr);
                    end
                end
                if (resp_val && resp_rdy) begin
                    pops++;
                    last_pop_cyc = cyc;
                    if (exp_q.size() == 0) check("unexpected_sample", int'(resp_data), -1);
                    else check("sample_data", int'(resp_data), int'(exp_q.pop_front()));
                end
                if (eng_active) begin
                    caps++;
                    last_cap_cyc = cyc;
                    eng_lfsr = lfsr_step(eng_lfsr);
                end
                if (eng_start) starts++;
                if (eng_stop) begin
                    stops++;
                    last_stop_caps = caps;
                end
                if (done) begin
                    dones++;
                    done_cyc = cyc;
                    check("done_with_data_left", occ + exp_q.size(), 0);
                end
                occ = occ + (eng_active ? 1 : 0) - ((resp_val && resp_rdy) ? 1 : 0);
                check("occupancy_bound", int'(occ <= DEPTH), 1);
                nxt_active = eng_start ? 1'b1 : (eng_stop ? 1'b0 : eng_active);
            end
        end
    endtask

    task automatic reset_pulse();
        drive_edge();
        rst = 1'b1;
        req_val = 1'b0;
        drive_edge();
        check("rst_req_rdy", int'(req_rdy), 1);
        check("rst_resp_val", int'(resp_val), 0);
        check("rst_eng_start", int'(eng_start), 0);
        check("rst_eng_stop", int'(eng_stop), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_state", int'(dbg_state), 0);
        rst = 1'b0;
    endtask

    task automatic issue(input int count);
        int a0;
        bit ok;
        a0 = accepts;
        ok = 1'b0;
        drive_edge();
        req_val = 1'b1;
        req_count = 8'(count);
        for (int i = 0; i < 40; i++) begin
            step();
            if (accepts > a0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", accepts - a0, 1);
        drive_edge();
        req_val = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        bit ok;
        d0 = dones;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (dones > d0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("done_timeout", dones - d0, 1);
    endtask

    task automatic wait_caps(input int target);
        for (int i = 0; i < 60; i++) begin
            if (caps >= target) break;
            step();
        end
        check("capture_wait", int'(caps >= target), 1);
    endtask

    initial begin
        int c0, s0, p0, st0, d0, a0, third_cyc;

        fork
            monitor_loop();
            forever begin
                @(posedge clk);
                cyc++;
            end
            forever begin
                @(posedge clk);
                #1;
                eng_active = nxt_active;
                eng_data   = eng_lfsr;
            end
            forever begin
                @(posedge clk);
                #1;
                if (rdy_mode == 1) resp_rdy = 1'($urandom_range(0, 1));
            end
        join_none

        vecs[0] = '{count: 1,   mode: 1, exp_pops: 1,   exp_no_start: 0};
        vecs[1] = '{count: 2,   mode: 1, exp_pops: 2,   exp_no_start: 0};
        vecs[2] = '{count: 5,   mode: 1, exp_pops: 5,   exp_no_start: 0};
        vecs[3] = '{count: 8,   mode: 0, exp_pops: 8,   exp_no_start: 0};
        vecs[4] = '{count: 0,   mode: 1, exp_pops: 0,   exp_no_start: 1};
        vecs[5] = '{count: 31,  mode: 1, exp_pops: 31,  exp_no_start: 0};
        vecs[6] = '{count: 255, mode: 1, exp_pops: 255, exp_no_start: 0};
        vecs[7] = '{count: 64,  mode: 1, exp_pops: 64,  exp_no_start: 0};

        reset_pulse();

        // Basic burst of three with the consumer always ready.
        rdy_mode = 0; resp_rdy = 1'b1;
        c0 = caps; st0 = stops; p0 = pops;
        issue(3);
        wait_done(60);
        check("basic_pops", pops - p0, 3);
        check("basic_stops", stops - st0, 1);
        check("basic_stop_at_capture", last_stop_caps - c0, 3);
        check("basic_done_after_empty", done_cyc - last_pop_cyc, 1);
        check("basic_queue_empty", exp_q.size(), 0);

        // Backpressure: consumer stalled, engine must pause at a full buffer.
        resp_rdy = 1'b0;
        c0 = caps; st0 = stops; p0 = pops; s0 = starts;
        issue(10);
        for (int i = 0; i < 20; i++) step();
        check("bp_captures_while_stalled", caps - c0, DEPTH);
        check("bp_stop_count", stops - st0, 1);
        check("bp_stop_at_capture", last_stop_caps - c0, DEPTH);
        check("bp_no_pops", pops - p0, 0);
        check("bp_resp_val", int'(resp_val), 1);
        drive_edge();
        resp_rdy = 1'b1;
        wait_done(200);
        check("bp_pops", pops - p0, 10);
        check("bp_captures", caps - c0, 10);
        check("bp_restarted", int'(starts - s0 >= 2), 1);

        // Zero-count request.
        s0 = starts; p0 = pops;
        issue(0);
        wait_done(10);
        check("zero_done_latency", int'(done_cyc - accept_cyc <= 2), 1);
        check("zero_no_start", starts - s0, 0);
        check("zero_no_pops", pops - p0, 0);
        step();
        check("zero_busy_after", int'(busy), 0);

        // Request held high across a burst of five.
        a0 = accepts; p0 = pops;
        drive_edge();
        req_val = 1'b1;
        req_count = 8'd5;
        for (int i = 0; i < 40; i++) begin
            step();
            if (accepts > a0) break;
        end
        for (int i = 0; i < 200; i++) begin
            step();
            if (accepts >= a0 + 2) break;
            check("held_req_rdy_low", int'(req_rdy), 0);
        end
        check("held_two_accepts", accepts - a0, 2);
        check("held_second_after_done", accept_cyc - done_cyc, 1);
        drive_edge();
        req_val = 1'b0;
        wait_done(100);
        check("held_pops", pops - p0, 10);

        // Reset during the second capture of a six-sample burst.
        c0 = caps;
        issue(6);
        wait_caps(c0 + 1);
        d0 = dones;
        reset_pulse();
        for (int i = 0; i < 10; i++) step();
        check("midrst_no_done", dones - d0, 0);
        check("midrst_idle", int'(busy), 0);
        check("midrst_queue_flushed", exp_q.size(), 0);

        // Full-rate streaming with occupancy held at DEPTH-1.
        resp_rdy = 1'b0;
        c0 = caps; st0 = stops; p0 = pops;
        issue(20);
        wait_caps(c0 + 3);
        third_cyc = last_cap_cyc;
        drive_edge();
        resp_rdy = 1'b1;
        wait_done(200);
        check("stream_stops", stops - st0, 1);
        check("stream_stop_at_last", last_stop_caps - c0, 20);
        check("stream_continuous", last_cap_cyc - third_cyc, 17);
        check("stream_pops", pops - p0, 20);

        // Table of bursts under random or constant consumer readiness.
        foreach (vecs[k]) begin
            rdy_mode = vecs[k].mode;
            resp_rdy = 1'b1;
            p0 = pops; s0 = starts;
            issue(vecs[k].count);
            wait_done(8 * vecs[k].count + 50);
            check("vec_pops", pops - p0, vecs[k].exp_pops);
            if (vecs[k].exp_no_start != 0) check("vec_no_start", starts - s0, 0);
            check("vec_queue_empty", exp_q.size(), 0);
            step();
            check("vec_busy_after", int'(busy), 0);
        end

        // Random burst lengths.
        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(0, 60));
            rdy_mode = 1;
            p0 = pops;
            issue(n);
            wait_done(8 * n + 50);
            check("rand_pops", pops - p0, n);
            check("rand_queue_empty", exp_q.size(), 0);
        end

        rdy_mode = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/random_sample_reader.md
RANDOM_SAMPLE_READER -- requirements
Module: random_sample_reader

Interface
REQ-001 The block SHALL expose parameter NBITS, default 8, meaning sample width in bits and the width of the engine state word.
REQ-002 The block SHALL expose parameter DEPTH, default 4, meaning sample buffer entries (power of two, at least 2).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the synchronous active-high reset.
REQ-005 The block SHALL have ports req_val (input, 1), req_rdy (output, 1) and req_count (input, 8), forming the burst request handshake; req_count is the number of samples.
REQ-006 The block SHALL have ports eng_start (output, 1), eng_stop (output, 1), eng_active (input, 1) and eng_data (input, NBITS), forming the engine control/data interface.
REQ-007 The block SHALL have ports resp_val (output, 1), resp_rdy (input, 1) and resp_data (output, NBITS), forming the sample output stream.
REQ-008 The block SHALL have ports busy (output, 1), high whenever state is not IDLE, and done (output, 1), a one-cycle pulse at burst completion.

Function
REQ-009 The FSM SHALL have exactly four states: IDLE, START, RUN, DRAIN.
REQ-010 IDLE: req_rdy=1; a request transfers when req_val&&req_rdy; count nonzero -> latch remaining=req_count, go START; count zero -> go DRAIN, no engine activity.
REQ-011 START: eng_start=1 iff buffer not full; the FSM SHALL go RUN in the cycle eng_start is asserted, else stay in START.
REQ-012 RUN: capture occurs when eng_active=1 and buffer not full; eng_data is pushed in that same cycle and remaining is decremented.
REQ-013 RUN with remaining=1 at capture: eng_stop=1 in that cycle, go DRAIN.
REQ-014 RUN when the capture fills the buffer (occupancy DEPTH-1, no pop in that cycle) and remaining>1: eng_stop=1 in that cycle, go START to resume once space exists.
REQ-015 eng_start and eng_stop SHALL never be asserted in the same cycle, and SHALL both be 0 in IDLE and DRAIN.
REQ-016 DRAIN: when the buffer is empty, done=1 for exactly one cycle, go IDLE.
REQ-017 Output stream: resp_val=buffer not empty; resp_data=oldest entry; pop on resp_val&&resp_rdy; push and pop in the same cycle are both honored with occupancy unchanged.
REQ-018 Order: samples SHALL leave in capture order; no sample is dropped or duplicated; exactly req_count samples per burst.
REQ-019 req_rdy=0 in every state except IDLE; req_val outside IDLE SHALL be ignored.
REQ-020 Latency: first capture no earlier than the cycle after eng_start; a captured sample is visible on resp_data the cycle after capture.
REQ-021 Count wrap: remaining SHALL be 8 bits and never decrement below 0; req_count=255 is a legal full burst.

Reset
REQ-022 On rst=1: state=IDLE, remaining=0, buffer emptied; req_rdy=1, resp_val=0, eng_start=0, eng_stop=0, busy=0, done=0 in the following cycle.
REQ-023 Reset mid-burst SHALL discard buffered samples and SHALL not produce a done pulse.

Structure
REQ-024 Shared package random_engine_pkg SHALL hold the FSM state encodings and the default NBITS/DEPTH constants.
REQ-025 The buffer SHALL be the sub-module sample_fifo (NBITS x DEPTH, push/pop/full/empty); the state and remaining registers SHALL reuse the existing Register cell.

Verification
REQ-026 The bench SHALL cover basic burst: req_count=3, resp_rdy=1, engine model advancing LFSR on start -> exactly 3 samples equal to model sequence, eng_stop on 3rd capture, done 1 cycle after buffer empties.
REQ-027 The bench SHALL cover backpressure: DEPTH=4, req_count=10, resp_rdy=0 for 20 cycles -> eng_stop at 4th capture, no capture while full; then resp_rdy=1 -> eng_start reissued and all 10 samples delivered in order.
REQ-028 The bench SHALL cover zero count: req_count=0 -> no eng_start, done pulses within 2 cycles, busy returns to 0.
REQ-029 The bench SHALL cover a request while busy: req_val held during burst of 5 -> req_rdy=0 throughout, second request accepted only after done.
REQ-030 The bench SHALL cover reset mid-burst: rst at 2nd of 6 captures -> resp_val=0, req_rdy=1 next cycle, no done pulse.
REQ-031 The bench SHALL cover simultaneous push/pop: resp_rdy=1 with occupancy DEPTH-1 -> no eng_stop, continuous capture each cycle.
